// File: rtl/bus_arbiter.sv
// Two-source round-robin bus arbiter with burst-limited preemption.
// Define BUS_ARB_TURNAROUND_EN to insert a one-cycle idle TURN state on every direct owner switch.
module bus_arbiter #(
  parameter int unsigned data_width = 8,
  parameter int unsigned max_burst  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req1,
  input  logic                  req2,
  input  logic [data_width-1:0] data_in1,
  input  logic [data_width-1:0] data_in2,
  output logic                  data_en1,
  output logic                  data_en2,
  output logic [data_width-1:0] data_out,
  output logic                  data_valid,
  output logic                  owner
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(max_burst - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
`ifdef BUS_ARB_TURNAROUND_EN
    , TURN = 2'd3
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             en1_q, en2_q;
`ifdef BUS_ARB_TURNAROUND_EN
  logic             turn_src_q, turn_src_d;
`endif

  logic cur_req;
  logic oth_req;
  logic oth_src;
  logic grant_go;
  logic grant_src;
  logic switch_go;

  // State, counter, owner and registered enables
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b1;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
`ifdef BUS_ARB_TURNAROUND_EN
      turn_src_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      en1_q   <= (state_d == GRANT1);
      en2_q   <= (state_d == GRANT2);
`ifdef BUS_ARB_TURNAROUND_EN
      turn_src_q <= turn_src_d;
`endif
    end
  end

  // Next-state: grant selection, burst limiting and switching
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
`ifdef BUS_ARB_TURNAROUND_EN
    turn_src_d = turn_src_q;
`endif
    cur_req   = (state_q == GRANT2) ? req2 : req1;
    oth_req   = (state_q == GRANT2) ? req1 : req2;
    oth_src   = (state_q == GRANT1);
    grant_go  = 1'b0;
    grant_src = 1'b0;
    switch_go = 1'b0;

    case (state_q)
      IDLE: begin
        if (req1 && req2) begin
          grant_go  = 1'b1;
          grant_src = ~owner_q;
        end else if (req1) begin
          grant_go  = 1'b1;
          grant_src = 1'b0;
        end else if (req2) begin
          grant_go  = 1'b1;
          grant_src = 1'b1;
        end
      end
      GRANT1, GRANT2: begin
        if (!cur_req) begin
          if (oth_req) switch_go = 1'b1;
          else         state_d   = IDLE;
        end else if (cnt_q == BURST_LAST) begin
          // Burst exhausted: yield if contended, else restart the burst
          if (oth_req) switch_go = 1'b1;
          else         cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef BUS_ARB_TURNAROUND_EN
      TURN: begin
        if (turn_src_q ? req2 : req1) begin
          grant_go  = 1'b1;
          grant_src = turn_src_q;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (switch_go) begin
`ifdef BUS_ARB_TURNAROUND_EN
      state_d    = TURN;
      turn_src_d = oth_src;
`else
      grant_go  = 1'b1;
      grant_src = oth_src;
`endif
    end

    if (grant_go) begin
      state_d = grant_src ? GRANT2 : GRANT1;
      owner_d = grant_src;
      cnt_d   = '0;
    end
  end

  // Shared buffer: enables are registered, payload passes through the selected source
  assign data_en1   = en1_q;
  assign data_en2   = en2_q;
  assign data_valid = en1_q | en2_q;
  assign owner      = owner_q;
  assign data_out   = en1_q ? data_in1 : (en2_q ? data_in2 : '0);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (default parameters).
// Expectations follow BUS_ARB_TURNAROUND_EN when it is defined for the build.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic       req1;
  logic       req2;
  logic [7:0] data_in1;
  logic [7:0] data_in2;
  logic       data_en1;
  logic       data_en2;
  logic [7:0] data_out;
  logic       data_valid;
  logic       owner;

  int checks;
  int failures;

  bus_arbiter #(.data_width(8), .max_burst(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req1       (req1),
    .req2       (req2),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .data_en1   (data_en1),
    .data_en2   (data_en2),
    .data_out   (data_out),
    .data_valid (data_valid),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enables must never overlap in any cycle
  always @(negedge clk) begin
    checks++;
    if ((data_en1 & data_en2) !== 1'b0) begin
      failures++;
      $display("FAIL mutex: data_en1=%b data_en2=%b required not both 1", data_en1, data_en2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req1 = 1'b1; req2 = 1'b1;
    data_in1 = 8'h01; data_in2 = 8'h02;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (data_en1 !== 1'b0 || data_en2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_en: en1=%b en2=%b required 0 0", data_en1, data_en2);
      end
      checks++;
      if (data_out !== 8'h00 || data_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_out: data_out=%h valid=%b required 00 0", data_out, data_valid);
      end
      checks++;
      if (owner !== 1'b1) begin
        failures++;
        $display("FAIL reset_owner: owner=%b required 1", owner);
      end
    end
    req1 = 1'b0; req2 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_grant();
    req1 = 1'b1; req2 = 1'b0; data_in1 = 8'h01;
    tick();
    checks++;
    if (data_en1 !== 1'b1 || data_en2 !== 1'b0 || data_out !== 8'h01) begin
      failures++;
      $display("FAIL single_grant: en1=%b en2=%b out=%h required 1 0 01", data_en1, data_en2, data_out);
    end
    checks++;
    if (owner !== 1'b0 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_owner: owner=%b valid=%b required 0 1", owner, data_valid);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL single_release: valid=%b out=%h required 0 00", data_valid, data_out);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_out [12];
    logic       exp_own [12];
`ifdef BUS_ARB_TURNAROUND_EN
    exp_out = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01, 8'h01};
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    exp_out = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h01};
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    data_in1 = 8'h01; data_in2 = 8'h02;
    req1 = 1'b1; req2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (data_out !== exp_out[i] || data_valid !== (exp_out[i] != 8'h00)) begin
        failures++;
        $display("FAIL rr_data[%0d]: out=%h valid=%b required %h %b", i, data_out, data_valid,
                 exp_out[i], (exp_out[i] != 8'h00));
      end
      checks++;
      if (owner !== exp_own[i]) begin
        failures++;
        $display("FAIL rr_owner[%0d]: owner=%b required %b", i, owner, exp_own[i]);
      end
    end
    req1 = 1'b0; req2 = 1'b0;
    tick();
  endtask

  task automatic test_long_burst();
    do_reset();
    req1 = 1'b1; req2 = 1'b0; data_in1 = 8'h5a;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (data_en1 !== 1'b1 || data_en2 !== 1'b0 || data_out !== 8'h5a) begin
        failures++;
        $display("FAIL long_burst[%0d]: en1=%b en2=%b out=%h required 1 0 5a", i, data_en1, data_en2, data_out);
      end
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_handoff();
    do_reset();
    data_in1 = 8'h11; data_in2 = 8'h22;
    req1 = 1'b1; req2 = 1'b0;
    tick();
    req1 = 1'b0; req2 = 1'b1;
`ifdef BUS_ARB_TURNAROUND_EN
    tick();
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL handoff_turn: valid=%b out=%h required 0 00", data_valid, data_out);
    end
`endif
    tick();
    checks++;
    if (data_en2 !== 1'b1 || data_en1 !== 1'b0 || data_out !== 8'h22 || owner !== 1'b1) begin
      failures++;
      $display("FAIL handoff_grant: en1=%b en2=%b out=%h owner=%b required 0 1 22 1",
               data_en1, data_en2, data_out, owner);
    end
    req2 = 1'b0;
    tick();
    checks++;
    if (data_valid !== 1'b0 || owner !== 1'b1) begin
      failures++;
      $display("FAIL handoff_idle: valid=%b owner=%b required 0 1", data_valid, owner);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    data_in1 = 8'h01; data_in2 = 8'h02;
    req1 = 1'b0; req2 = 1'b1;
    tick();
    tick();
    checks++;
    if (data_en2 !== 1'b1 || data_out !== 8'h02) begin
      failures++;
      $display("FAIL mid_pre: en2=%b out=%h required 1 02", data_en2, data_out);
    end
    rst = 1'b1; req1 = 1'b1;
    tick();
    checks++;
    if (data_en2 !== 1'b0 || data_en1 !== 1'b0 || data_out !== 8'h00 || owner !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: en1=%b en2=%b out=%h owner=%b required 0 0 00 1",
               data_en1, data_en2, data_out, owner);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (data_en1 !== 1'b1 || data_en2 !== 1'b0 || data_out !== 8'h01 || owner !== 1'b0) begin
      failures++;
      $display("FAIL mid_regrant: en1=%b en2=%b out=%h owner=%b required 1 0 01 0",
               data_en1, data_en2, data_out, owner);
    end
    req1 = 1'b0; req2 = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req1     = 1'b0;
    req2     = 1'b0;
    data_in1 = 8'h00;
    data_in2 = 8'h00;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_long_burst();
    test_handoff();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
